move_replayer: RTL and testbench
================================

# move_replayer

Downstream consumer of the move deque in the maze datapath. Once the solver raises Finish, this block drains the recorded moves from the deque front in order. It replays each move against its own X/Y position registers and presents every step on a valid/ready output port. At the end it reports the path length and whether the replayed path ended on the target cell without leaving the 16x16 grid.

## Interface
- START_X, 0: replay start column (4-bit)
- START_Y, 15: replay start row (4-bit)
- END_X, 15: required final column
- END_Y, 0: required final row
- Clk  in  1  clock, all state on rising edge
- our_reset  in  1  reset, asynchronous, active-high
- start  in  1  one-cycle pulse (driven from Finish); begins a replay
- is_deque_empty  in  1  deque empty flag
- stack_out  in  2  deque read data, registered by the deque on the edge ending a pop_front cycle
- pop_front  out  1  one-cycle pop request to the deque
- out_valid  out  1  step available on out_move/out_x/out_y
- out_ready  in  1  downstream accepts the step when out_valid & out_ready
- out_move  out  2  move of the current step
- out_x  out  4  column after applying out_move
- out_y  out  4  row after applying out_move
- step_count  out  8  number of accepted steps in this replay
- busy  out  1  replay in progress
- done  out  1  replay finished, held until the next start
- error  out  1  sticky; grid exit, wrong final cell or step overflow

## Operation
- Move encoding:
  - 00: X+1
  - 01: Y+1
  - 10: X-1
  - 11: Y-1
- Arithmetic is 4-bit modulo 16. Any wrap (X=15 with 00, X=0 with 10, Y=15 with 01, Y=0 with 11) sets error. The wrapped coordinate is still output.
- FSM states: IDLE, POP, LOAD, EMIT, CHECK, DONE.
- IDLE or DONE + start:
  - Load X=START_X, Y=START_Y.
  - Clear step_count and error. Clear done.
  - If is_deque_empty, go to CHECK. Otherwise go to POP.
- POP: pop_front=1 for exactly this cycle, then go to LOAD.
- LOAD:
  - Capture stack_out into the move register.
  - Compute the next X/Y into the out_x/out_y registers. Set the wrap error.
  - Go to EMIT.
- EMIT:
  - out_valid=1. out_move/out_x/out_y are held stable while out_ready=0.
  - On handshake, increment step_count.
  - If step_count was 255, set error and saturate at 255.
  - If is_deque_empty, go to CHECK. Otherwise go to POP.
- CHECK: set error if (X,Y) != (END_X,END_Y), then go to DONE.
- DONE: done=1. Only start leaves DONE.
- start outside IDLE/DONE is ignored.
- busy=1 in POP, LOAD, EMIT and CHECK.
- Empty deque at start → zero steps. error=1 unless START equals END.

## Timing
- Reset values:
  - state IDLE
  - pop_front, out_valid, busy, done, error: 0
  - out_move: 00
  - out_x: START_X; out_y: START_Y
  - step_count: 0
- Reset is asynchronous. pop_front and out_valid drop immediately on reset, including mid-replay. No partial state survives.
- start at edge N → POP during cycle N+1.
- pop_front in cycle P → stack_out is sampled at the end of P+1 (LOAD) → out_valid from P+2.
- Throughput with out_ready tied high: one step per 3 cycles.
- is_deque_empty is sampled only in IDLE/DONE (on start) and in EMIT (on handshake). It is never sampled in POP or LOAD.
- done rises the cycle after CHECK and is stable until a start is accepted.

## Test plan
- Reset mid-EMIT (out_valid=1, out_ready=0) → same cycle: out_valid=0, pop_front=0. Next edge: IDLE, step_count=0, out_x=0, out_y=15.
- Deque preloaded with the 30 moves 00×15 then 11×15, out_ready=1, start pulse → 30 handshakes, last step (15,0), step_count=30, done=1, error=0, exactly 30 pop_front pulses, 3 cycles/step.
- Same 30 moves, out_ready low for 5 cycles on step 7 → out_move=00, out_x=7, out_y=15 held all 5 cycles, no extra pop_front, final result unchanged.
- Moves 01,00 from (0,15) → step 1 out_y=0 (wrap), error=1 and stays 1 through DONE.
- Empty deque, start → no pop_front, step_count=0, done=1 two cycles later, error=1.
- start re-pulsed while busy → ignored. start in DONE → step_count cleared, error cleared, replay restarts from (0,15).

Source files
------------

// File: rtl/move_replayer.sv
// Drains recorded maze moves from the deque front, replays them against a local
// X/Y position and streams each step out over a valid/ready port.
module move_replayer #(
  parameter logic [3:0] START_X = 4'd0,
  parameter logic [3:0] START_Y = 4'd15,
  parameter logic [3:0] END_X   = 4'd15,
  parameter logic [3:0] END_Y   = 4'd0
) (
  input  logic       Clk,
  input  logic       our_reset,
  input  logic       start,
  input  logic       is_deque_empty,
  input  logic [1:0] stack_out,
  output logic       pop_front,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [1:0] out_move,
  output logic [3:0] out_x,
  output logic [3:0] out_y,
  output logic [7:0] step_count,
  output logic       busy,
  output logic       done,
  output logic       error
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] POP   = 3'd1;
  localparam logic [2:0] LOAD  = 3'd2;
  localparam logic [2:0] EMIT  = 3'd3;
  localparam logic [2:0] CHECK = 3'd4;
  localparam logic [2:0] DONE  = 3'd5;

  logic [2:0] state;
  logic [3:0] nxt_x;
  logic [3:0] nxt_y;
  logic       wrap;

  // Outputs decode straight from state, so the async reset clears them at once.
  assign pop_front = (state == POP);
  assign out_valid = (state == EMIT);
  assign busy      = (state == POP) || (state == LOAD) || (state == EMIT) || (state == CHECK);
  assign done      = (state == DONE);

  // out_x/out_y double as the replay position: the step result is the new position.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a latch behind.
    nxt_x = out_x;
    nxt_y = out_y;
    wrap  = 1'b0;
    unique case (stack_out)
      2'b00: begin nxt_x = out_x + 4'd1; wrap = (out_x == 4'hF); end
      2'b01: begin nxt_y = out_y + 4'd1; wrap = (out_y == 4'hF); end
      2'b10: begin nxt_x = out_x - 4'd1; wrap = (out_x == 4'h0); end
      2'b11: begin nxt_y = out_y - 4'd1; wrap = (out_y == 4'h0); end
    endcase
  end

  always_ff @(posedge Clk or posedge our_reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // sees the pre-edge values of the others.
    if (our_reset) begin
      state      <= IDLE;
      out_move   <= 2'b00;
      out_x      <= START_X;
      out_y      <= START_Y;
      step_count <= 8'd0;
      error      <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            out_x      <= START_X;
            out_y      <= START_Y;
            step_count <= 8'd0;
            error      <= 1'b0;
            state      <= is_deque_empty ? CHECK : POP;
          end
        end
        POP: state <= LOAD;
        LOAD: begin
          // stack_out is valid here: the deque registered it on the edge ending POP.
          out_move <= stack_out;
          out_x    <= nxt_x;
          out_y    <= nxt_y;
          if (wrap) error <= 1'b1;
          state    <= EMIT;
        end
        EMIT: begin
          if (out_ready) begin
            if (step_count == 8'hFF) error <= 1'b1;
            else                     step_count <= step_count + 8'd1;
            state <= is_deque_empty ? CHECK : POP;
          end
        end
        CHECK: begin
          if ((out_x != END_X) || (out_y != END_Y)) error <= 1'b1;
          state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_move_replayer.sv
// Directed bench for move_replayer: single-move vector table plus hand-built
// replays covering back-pressure, wrap, empty deque, overflow and async reset.
module tb_move_replayer;

  logic       clk = 1'b0;
  logic       our_reset = 1'b1;
  logic       start = 1'b0;
  logic       is_deque_empty;
  logic [1:0] stack_out = 2'b00;
  logic       pop_front;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [1:0] out_move;
  logic [3:0] out_x;
  logic [3:0] out_y;
  logic [7:0] step_count;
  logic       busy;
  logic       done;
  logic       error;

  move_replayer dut (
    .Clk           (clk),
    .our_reset     (our_reset),
    .start         (start),
    .is_deque_empty(is_deque_empty),
    .stack_out     (stack_out),
    .pop_front     (pop_front),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_move      (out_move),
    .out_x         (out_x),
    .out_y         (out_y),
    .step_count    (step_count),
    .busy          (busy),
    .done          (done),
    .error         (error)
  );

  always #5 clk = ~clk;

  // Deque model: registers the front entry on the edge ending a pop cycle.
  logic [1:0] mem [0:299];
  int dq_len = 0;
  int rd_ptr = 0;
  int pop_cnt = 0;
  logic dq_clear = 1'b0;

  always @(posedge clk) begin
    if (dq_clear) begin
      rd_ptr  <= 0;
      pop_cnt <= 0;
    end else if (pop_front) begin
      pop_cnt <= pop_cnt + 1;
      if (rd_ptr < dq_len) begin
        stack_out <= mem[rd_ptr];
        rd_ptr    <= rd_ptr + 1;
      end
    end
  end

  assign is_deque_empty = (rd_ptr >= dq_len);

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Results of the most recent replay.
  int hs;
  int bad_gap;
  int done_cyc;
  logic [3:0] mx, my;
  logic err_trace [0:299];

  task automatic run_replay(input int len, input int stall_at, input int stall_len,
                            input int busy_start_cyc);
    int stalled;
    bit fin;
    logic [3:0] ex, ey;
    logic [1:0] mv;
    dq_len    = len;
    dq_clear  = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    dq_clear = 1'b0;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_clear", {busy, done, error, step_count}, {1'b1, 1'b0, 1'b0, 8'd0});
    mx = 4'd0; my = 4'd15;
    hs = 0; bad_gap = 0; stalled = 0; fin = 1'b0; done_cyc = -1;
    for (int cyc = 1; cyc <= 1000 && !fin; cyc++) begin
      @(negedge clk);
      start = (cyc == busy_start_cyc);
      if (cyc == busy_start_cyc) check("busy_at_restart", busy, 1);
      if (done) begin
        fin = 1'b1;
        done_cyc = cyc;
      end else if (out_valid) begin
        mv = (hs < 300) ? mem[hs] : 2'b00;
        ex = mx; ey = my;
        case (mv)
          2'b00: ex = mx + 4'd1;
          2'b01: ey = my + 4'd1;
          2'b10: ex = mx - 4'd1;
          default: ey = my - 4'd1;
        endcase
        if (hs == stall_at && stalled < stall_len) begin
          out_ready = 1'b0;
          stalled++;
          check("stall_hold", {out_move, out_x, out_y}, {mv, ex, ey});
          check("stall_no_pop", pop_front, 0);
        end else begin
          out_ready = 1'b1;
          check("step", {out_move, out_x, out_y}, {mv, ex, ey});
          if (hs < 300) err_trace[hs] = error;
          if (stall_len == 0 && cyc != 2 + 3 * hs) bad_gap++;
          mx = ex; my = ey;
          hs++;
        end
      end else begin
        out_ready = 1'b1;
      end
    end
    start = 1'b0;
    check("replay_finished", fin, 1);
  endtask

  task automatic final_checks(input int len, input logic [3:0] fx, input logic [3:0] fy,
                              input logic ferr);
    check("steps_seen", hs, len);
    check("pops", pop_cnt, len);
    check("step_count", step_count, (len > 255) ? 255 : len);
    check("done", done, 1);
    check("error", error, ferr);
    check("final_xy", {out_x, out_y}, {fx, fy});
  endtask

  task automatic load_diag();
    for (int i = 0; i < 15; i++) mem[i] = 2'b00;
    for (int i = 15; i < 30; i++) mem[i] = 2'b11;
  endtask

  typedef struct packed {
    logic [1:0] move;
    logic [3:0] x;
    logic [3:0] y;
    logic       err;
  } vec_t;

  vec_t vecs [4];

  initial begin
    // One move from (0,15): expected position and wrap error after LOAD.
    vecs[0] = '{move: 2'b00, x: 4'd1,  y: 4'd15, err: 1'b0};
    vecs[1] = '{move: 2'b01, x: 4'd0,  y: 4'd0,  err: 1'b1};
    vecs[2] = '{move: 2'b10, x: 4'd15, y: 4'd15, err: 1'b1};
    vecs[3] = '{move: 2'b11, x: 4'd0,  y: 4'd14, err: 1'b0};

    @(negedge clk);
    @(negedge clk);
    check("reset_ctrl", {pop_front, out_valid, busy, done, error}, 5'b00000);
    check("reset_data", {out_move, out_x, out_y, step_count}, {2'b00, 4'd0, 4'd15, 8'd0});
    our_reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 4; i++) begin
      mem[0] = vecs[i].move;
      run_replay(1, -1, 0, -1);
      check("vec_xy", {out_x, out_y}, {vecs[i].x, vecs[i].y});
      check("vec_wrap_err", err_trace[0], vecs[i].err);
      final_checks(1, vecs[i].x, vecs[i].y, 1'b1);
    end

    // Full diagonal path, ready tied high.
    load_diag();
    run_replay(30, -1, 0, -1);
    final_checks(30, 4'd15, 4'd0, 1'b0);
    check("three_cycles_per_step", bad_gap, 0);

    // Back-pressure for 5 cycles on step 7.
    run_replay(30, 6, 5, -1);
    final_checks(30, 4'd15, 4'd0, 1'b0);

    // start while busy is ignored.
    run_replay(30, -1, 0, 20);
    final_checks(30, 4'd15, 4'd0, 1'b0);
    check("gaps_after_busy_start", bad_gap, 0);

    // Wrap on the first step, error sticky to DONE.
    mem[0] = 2'b01;
    mem[1] = 2'b00;
    run_replay(2, -1, 0, -1);
    check("wrap_err_step2", err_trace[1], 1);
    final_checks(2, 4'd1, 4'd0, 1'b1);

    // Restart from DONE clears error and replays from (0,15).
    load_diag();
    run_replay(30, -1, 0, -1);
    final_checks(30, 4'd15, 4'd0, 1'b0);

    // Empty deque.
    run_replay(0, -1, 0, -1);
    final_checks(0, 4'd0, 4'd15, 1'b1);
    check("empty_done_latency", done_cyc, 1);

    // 256 in-grid steps ending on target: only the step overflow flags error.
    for (int k = 0; k < 113; k++) begin
      mem[2 * k]     = 2'b00;
      mem[2 * k + 1] = 2'b10;
    end
    for (int i = 226; i < 241; i++) mem[i] = 2'b00;
    for (int i = 241; i < 256; i++) mem[i] = 2'b11;
    run_replay(256, -1, 0, -1);
    check("no_err_before_overflow", err_trace[255], 0);
    final_checks(256, 4'd15, 4'd0, 1'b1);

    // Asynchronous reset while stalled in EMIT on step 3.
    load_diag();
    dq_len    = 30;
    dq_clear  = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    dq_clear = 1'b0;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (out_valid && step_count == 8'd2) begin
        out_ready = 1'b0;
        break;
      end
    end
    check("emit_before_reset", {out_valid, out_x, out_y}, {1'b1, 4'd3, 4'd15});
    #2 our_reset = 1'b1;
    #1;
    check("rst_async", {out_valid, pop_front}, 2'b00);
    @(negedge clk);
    check("rst_state", {busy, done, error, step_count, out_x, out_y},
          {1'b0, 1'b0, 1'b0, 8'd0, 4'd0, 4'd15});
    our_reset = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
